fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO: next generation of the 8-bit byte FIFO used between the 1-wire bit engine and the host side.
- Generic data width and power-of-two depth.
- Accepts a read and a write in the same cycle; no busy turnaround.
- Adds occupancy count, full/empty and almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- do_write  in  1  write request, sampled every cycle.
- di  in  WIDTH  write data.
- do_read  in  1  read request, sampled every cycle.
- do  out  WIDTH  read data, registered.
- write_ack  out  1  pulse: the write presented in the previous cycle was stored.
- read_ack  out  1  pulse: do holds the word popped in the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async, active-high):
  - Pointers and count cleared; do = 0.
  - write_ack = read_ack = overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = almost_full = 0.
  - Memory contents undefined.
  - Reset asserted mid-transfer discards all data; the first cycle after release behaves as an empty FIFO.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit and the low ADDR_W bits address memory.
  - full and empty are derived from count, which is a registered counter.
  - Pointers wrap naturally modulo 2*DEPTH.
- Acceptance, evaluated from the state at the clock edge:
  - rd_ok = do_read & ~empty.
  - wr_ok = do_write & (~full | rd_ok). Write while full is allowed only together with a read in the same cycle.
- Write: on wr_ok, mem[wr_ptr] <= di, wr_ptr += 1, write_ack = 1 for one cycle.
- Read:
  - On rd_ok, do <= mem[rd_ptr], rd_ptr += 1, read_ack = 1 for one cycle.
  - Read latency is 1 cycle: data is valid in the cycle read_ack is high.
  - do holds its last value when no read is accepted.
- Simultaneous read and write:
  - Both accepted: count unchanged, both acks high.
  - On empty, only the write is accepted (no fall-through). read_ack = 0 and underflow sets.
- Count: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither. All flags are combinational from the registered count.
- Errors:
  - overflow <= 1 on do_write & ~wr_ok.
  - underflow <= 1 on do_read & ~rd_ok.
  - Both stay set until reset or flush.
- Flush:
  - Clears pointers, count, overflow, underflow and both acks; do is unchanged.
  - Has priority over a same-cycle read and write, which are discarded without setting error flags.
- Continuous do_write and do_read every cycle sustain 1 word/cycle throughput.

Test Plan (WIDTH=8, ADDR_W=4, DEPTH=16, AF=14, AE=2):
- Reset release, no requests -> empty=1, almost_empty=1, count=0, do=0x00, both acks 0.
- Write 0x01..0x10 on 16 consecutive cycles, then write 0xAA -> almost_full sets at count 14, full at 16, 0xAA not acked, overflow=1. Then 16 reads -> do = 0x01..0x10 in order, each valid with read_ack; empty=1 after the last read.
- Read on empty FIFO -> read_ack=0, underflow=1, count stays 0. Simultaneous write 0x55 + read on empty -> write_ack=1, read_ack=0, count=1.
- Full FIFO, same cycle do_write=0x77 and do_read -> both acked, count stays 16, do=oldest word; 0x77 is read out last.
- Wrap: 40 cycles of streaming write+read with data = cycle index -> reads match writes in order, count constant, no error flags.
- Fill 5 words with overflow set, then flush with do_write high -> count=0, empty=1, overflow=0, no write_ack. Async reset pulse mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle of the parametrised synchronous FIFO.
// master = requester side, slave = the FIFO itself.
interface fifo_sync_param_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              do_write;
    logic [WIDTH-1:0]  di;
    logic              do_read;
    logic [WIDTH-1:0]  dout;
    logic              write_ack;
    logic              read_ack;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, do_write, di, do_read,
        input  dout, write_ack, read_ack, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, do_write, di, do_read,
        output dout, write_ack, read_ack, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO, power-of-two depth, registered read data, occupancy
// thresholds, sticky overflow/underflow and synchronous flush.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = (2**ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input logic                clock,
    input logic                reset,
    fifo_sync_param_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr, rd_ptr, cnt;
    logic [WIDTH-1:0] dout_q;
    logic             wack_q, rack_q, ovf_q, unf_q;
    logic             rd_ok, wr_ok;

    // A write into a full FIFO is legal only when a read frees a slot this cycle.
    assign rd_ok = bus.do_read & (cnt != '0);
    assign wr_ok = bus.do_write & ((cnt != DEPTH_C) | rd_ok);

    assign bus.dout         = dout_q;
    assign bus.write_ack    = wack_q;
    assign bus.read_ack     = rack_q;
    assign bus.count        = cnt;
    assign bus.empty        = (cnt == '0);
    assign bus.full         = (cnt == DEPTH_C);
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    always_ff @(posedge clock) begin
        if (wr_ok && !bus.flush)
            mem[wr_ptr[ADDR_W-1:0]] <= bus.di;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
            wack_q <= 1'b0;
            rack_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wack_q <= 1'b0;
            rack_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wack_q <= wr_ok;
            rack_q <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (bus.do_write && !wr_ok)
                ovf_q <= 1'b1;
            if (bus.do_read && !rd_ok)
                unf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_fifo_sync_param;
    localparam int WIDTH = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_sync_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fifo_sync_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] m_do;
    bit         m_wack, m_rack, m_ovf, m_unf;

    typedef struct {
        bit         fl, wr, rd;
        logic [7:0] di;
        int         exp_count;
        bit         exp_wack, exp_rack, exp_ovf, exp_unf;
        logic [7:0] exp_do;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n = q.size();
        chk({tag, ".count"}, int'(bus.count), n);
        chk({tag, ".empty"}, int'(bus.empty), int'(n == 0));
        chk({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
        chk({tag, ".almost_full"}, int'(bus.almost_full), int'(n >= AF));
        chk({tag, ".almost_empty"}, int'(bus.almost_empty), int'(n <= AE));
        chk({tag, ".write_ack"}, int'(bus.write_ack), int'(m_wack));
        chk({tag, ".read_ack"}, int'(bus.read_ack), int'(m_rack));
        chk({tag, ".do"}, int'(bus.dout), int'(m_do));
        chk({tag, ".overflow"}, int'(bus.overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(bus.underflow), int'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_do = 8'h00;
        m_wack = 0; m_rack = 0; m_ovf = 0; m_unf = 0;
    endtask

    // One clock: update the model from the pre-edge occupancy, drive, check.
    task automatic step(input bit fl, input bit wr, input logic [7:0] d, input bit rd,
                        input string tag);
        bit rok, wok;
        if (fl) begin
            q.delete();
            m_wack = 0; m_rack = 0; m_ovf = 0; m_unf = 0;
        end else begin
            rok = rd && (q.size() != 0);
            wok = wr && ((q.size() < DEPTH) || rok);
            if (rd && !rok) m_unf = 1;
            if (wr && !wok) m_ovf = 1;
            if (rok) m_do = q.pop_front();
            if (wok) q.push_back(d);
            m_wack = wok;
            m_rack = rok;
        end
        bus.flush = fl; bus.do_write = wr; bus.di = d; bus.do_read = rd;
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset();
        bus.flush = 0; bus.do_write = 0; bus.do_read = 0; bus.di = '0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        bus.flush = 0; bus.do_write = 0; bus.do_read = 0; bus.di = '0;
        vt[0] = '{fl:0, wr:0, rd:1, di:8'h00, exp_count:0, exp_wack:0, exp_rack:0, exp_ovf:0, exp_unf:1, exp_do:8'h00};
        vt[1] = '{fl:0, wr:1, rd:1, di:8'h55, exp_count:1, exp_wack:1, exp_rack:0, exp_ovf:0, exp_unf:1, exp_do:8'h00};
        vt[2] = '{fl:0, wr:0, rd:1, di:8'h00, exp_count:0, exp_wack:0, exp_rack:1, exp_ovf:0, exp_unf:1, exp_do:8'h55};
        vt[3] = '{fl:0, wr:1, rd:0, di:8'h12, exp_count:1, exp_wack:1, exp_rack:0, exp_ovf:0, exp_unf:1, exp_do:8'h55};
        vt[4] = '{fl:1, wr:1, rd:1, di:8'h34, exp_count:0, exp_wack:0, exp_rack:0, exp_ovf:0, exp_unf:0, exp_do:8'h55};
        vt[5] = '{fl:0, wr:1, rd:0, di:8'h9A, exp_count:1, exp_wack:1, exp_rack:0, exp_ovf:0, exp_unf:0, exp_do:8'h55};
        vt[6] = '{fl:0, wr:0, rd:1, di:8'h00, exp_count:0, exp_wack:0, exp_rack:1, exp_ovf:0, exp_unf:0, exp_do:8'h9A};

        #2;
        apply_reset();
        @(posedge clock); #1;
        check_all("idle_after_reset");

        // directed table: empty-side corners and flush priority
        for (int i = 0; i < 7; i++) begin
            step(vt[i].fl, vt[i].wr, vt[i].di, vt[i].rd, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_count", i), int'(bus.count), vt[i].exp_count);
            chk($sformatf("vec%0d.tbl_wack", i), int'(bus.write_ack), int'(vt[i].exp_wack));
            chk($sformatf("vec%0d.tbl_rack", i), int'(bus.read_ack), int'(vt[i].exp_rack));
            chk($sformatf("vec%0d.tbl_do", i), int'(bus.dout), int'(vt[i].exp_do));
            chk($sformatf("vec%0d.tbl_ovf", i), int'(bus.overflow), int'(vt[i].exp_ovf));
            chk($sformatf("vec%0d.tbl_unf", i), int'(bus.underflow), int'(vt[i].exp_unf));
        end

        // fill to full, reject one, then write+read while full
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'(i), 0, $sformatf("fill%0d", i));
            if (i == 13) chk("fill13.af_low", int'(bus.almost_full), 0);
            if (i == 14) chk("fill14.af_set", int'(bus.almost_full), 1);
        end
        chk("fill.full", int'(bus.full), 1);
        step(0, 1, 8'hAA, 0, "over");
        chk("over.ovf", int'(bus.overflow), 1);
        chk("over.nack", int'(bus.write_ack), 0);
        step(0, 1, 8'h77, 1, "full_rw");
        chk("full_rw.do", int'(bus.dout), 8'h01);
        chk("full_rw.count", int'(bus.count), 16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1, $sformatf("drain%0d", i));
            chk($sformatf("drain%0d.data", i), int'(bus.dout), (i < 15) ? i + 2 : 8'h77);
        end
        chk("drain.empty", int'(bus.empty), 1);

        // wrap: streaming read+write keeps count constant with no errors
        step(1, 0, 8'h00, 0, "pre_flush");
        step(0, 1, 8'hF0, 0, "preload");
        for (int i = 0; i < 40; i++)
            step(0, 1, 8'(i), 1, $sformatf("stream%0d", i));
        chk("stream.count", int'(bus.count), 1);
        chk("stream.last_do", int'(bus.dout), 38);
        chk("stream.no_err", int'(bus.overflow | bus.underflow), 0);

        // flush with overflow set and write pending
        apply_reset();
        for (int i = 0; i < 17; i++) step(0, 1, 8'(8'h30 + i), 0, "f_fill");
        for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1, "f_read");
        chk("f5.count", int'(bus.count), 5);
        step(1, 1, 8'hEE, 0, "flush");
        chk("flush.ovf_clr", int'(bus.overflow), 0);
        chk("flush.empty", int'(bus.empty), 1);

        // async reset mid-stream
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'hC0 + i), (i > 2), "pre_rst");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        step(0, 0, 8'h00, 1, "post_rst_rd");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            step(r < 2, $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
